dm_access_unit: RTL

DM_ACCESS_UNIT -- requirements
Module: dm_access_unit

---
 rtl/dm_access_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dm_access_unit.sv
// Data-memory access unit: turns a pipeline load/store into a held memory
// request, stalling the pipeline until the memory answers.
module dm_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        DM_en,
   input  logic        DM_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        misalign,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rword_q, rword_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        we_q, we_d;
   logic        rst_hold_q, rst_hold_d;

   logic        aligned;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_ext;

   always_comb begin
      aligned = 1'b0;
      case (funct3)
         3'b000, 3'b100: aligned = 1'b1;
         3'b001, 3'b101: aligned = ~addr[0];
         3'b010:         aligned = (addr[1:0] == 2'b00);
         default:        aligned = 1'b0;
      endcase
   end

   always_comb begin
      lane_byte = 8'(rword_q >> {addr_q[1:0], 3'b000});
      lane_half = addr_q[1] ? rword_q[31:16] : rword_q[15:0];
      load_ext  = '0;
      case (funct3_q)
         3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
         3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
         3'b100:  load_ext = {24'h000000, lane_byte};
         3'b101:  load_ext = {16'h0000, lane_half};
         3'b010:  load_ext = rword_q;
         default: load_ext = '0;
      endcase
   end

   // rst_hold keeps the cycle just after reset quiet even if DM_en is high.
   assign rst_hold_d = rst;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rword_d   = rword_q;
      funct3_d  = funct3_q;
      we_d      = we_q;
      stall     = 1'b0;
      misalign  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wstrb = '0;
      mem_wdata = '0;
      rdata     = '0;
      case (state_q)
         IDLE: begin
            if (DM_en && !rst_hold_q) begin
               if (aligned) begin
                  addr_d   = addr;
                  wdata_d  = wdata;
                  funct3_d = funct3;
                  we_d     = DM_write;
                  stall    = 1'b1;
                  state_d  = REQ;
               end else begin
                  misalign = 1'b1;
               end
            end
         end
         REQ: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_we   = we_q;
            mem_addr = {addr_q[31:2], 2'b00};
            if (we_q) begin
               case (funct3_q[1:0])
                  2'b00: begin
                     mem_wstrb = 4'b0001 << addr_q[1:0];
                     mem_wdata = {4{wdata_q[7:0]}};
                  end
                  2'b01: begin
                     mem_wstrb = 4'b0011 << addr_q[1:0];
                     mem_wdata = {2{wdata_q[15:0]}};
                  end
                  default: begin
                     mem_wstrb = 4'b1111;
                     mem_wdata = wdata_q;
                  end
               endcase
            end
            if (mem_ready) begin
               rword_d = mem_rdata;
               state_d = DONE;
            end
         end
         DONE: begin
            if (!we_q) rdata = load_ext;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         stall     = 1'b0;
         misalign  = 1'b0;
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wstrb = '0;
         mem_wdata = '0;
         rdata     = '0;
      end
   end

   always_ff @(posedge clk) begin
      rst_hold_q <= rst_hold_d;
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rword_q  <= '0;
         funct3_q <= '0;
         we_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rword_q  <= rword_d;
         funct3_q <= funct3_d;
         we_q     <= we_d;
      end
   end

endmodule
